// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port SRAM, one transaction in flight (IDLE->ISSUE->RESP).
// Build option MEM_ARB_RR_EN: round-robin tie-break; otherwise port 1 has fixed priority.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 22,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  p0_valid_i,
  output logic                  p0_ready_o,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [DATA_WIDTH-1:0] p0_wdata_i,
  input  logic [STRB_WIDTH-1:0] p0_wstrb_i,
  output logic [DATA_WIDTH-1:0] p0_rdata_o,
  input  logic                  p1_valid_i,
  output logic                  p1_ready_o,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [DATA_WIDTH-1:0] p1_wdata_i,
  input  logic [STRB_WIDTH-1:0] p1_wstrb_i,
  output logic [DATA_WIDTH-1:0] p1_rdata_o,
  output logic [STRB_WIDTH-1:0] mem_wen_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  grant_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e                state_q;
  logic                  grant_q;
  logic                  p0_ready_q, p1_ready_q;
  logic [DATA_WIDTH-1:0] p0_rdata_q, p1_rdata_q;
  logic [STRB_WIDTH-1:0] mem_wen_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  win_d;

`ifdef MEM_ARB_RR_EN
  // rr_q names the port favoured on the next tie
  logic rr_q;

  always_comb begin
    win_d = p1_valid_i;
    if (p0_valid_i && p1_valid_i) win_d = rr_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      rr_q <= 1'b0;
    else if (state_q == RESP)
      rr_q <= ~grant_q;
  end
`else
  always_comb begin
    win_d = p1_valid_i;
  end
`endif

  // The SRAM address/data/strobe registers double as the request latch, so the
  // SRAM sees the request during ISSUE and its registered read lands in RESP.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      p0_ready_q  <= 1'b0;
      p1_ready_q  <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      mem_wen_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      p0_ready_q <= 1'b0;
      p1_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          mem_wen_q <= '0;
          if (p0_valid_i || p1_valid_i) begin
            grant_q     <= win_d;
            mem_addr_q  <= win_d ? p1_addr_i  : p0_addr_i;
            mem_wdata_q <= win_d ? p1_wdata_i : p0_wdata_i;
            mem_wen_q   <= win_d ? p1_wstrb_i : p0_wstrb_i;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_wen_q <= '0;
          state_q   <= RESP;
        end
        RESP: begin
          mem_wen_q <= '0;
          if (grant_q) begin
            p1_rdata_q <= mem_rdata_i;
            p1_ready_q <= 1'b1;
          end else begin
            p0_rdata_q <= mem_rdata_i;
            p0_ready_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: begin
          mem_wen_q <= '0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // Gate strobes with reset so a write caught in ISSUE never reaches the SRAM edge.
  assign mem_wen_o   = reset_i ? '0 : mem_wen_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign p0_ready_o  = p0_ready_q;
  assign p1_ready_o  = p1_ready_q;
  assign p0_rdata_o  = p0_rdata_q;
  assign p1_rdata_o  = p1_rdata_q;
  assign grant_o     = grant_q;

endmodule
